csr_trap_ctrl: RTL and testbench

Sequencer sitting directly upstream of the machine-mode CSR register file. It turns single-cycle requests from the execute stage (ecall trap, mret, CSRRW/CSRRS/CSRRC) into the ordered single-port write/read accesses the CSR file needs. It also returns the PC redirect for traps and mret, and the old CSR value for CSR instructions. The CSR file has one write port and a combinational read port, so traps take several cycles; the core stalls on `ready_o`.

---
 rtl/csr_trap_ctrl_pkg.sv | 32 +++
 rtl/csr_trap_ctrl_alu.sv | 35 +++
 rtl/csr_trap_ctrl.sv | 154 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared CSR addresses, op codes and sequencer state encodings for csr_trap_ctrl.
// The MSTATUS states exist only when CSR_TRAP_MSTATUS_EN is defined.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    OP_RO = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_VEC   = 3'd3,
    S_M_EPC   = 3'd4,
`ifdef CSR_TRAP_MSTATUS_EN
    S_C_RMW   = 3'd5,
    S_T_MST   = 3'd6,
    S_M_MST   = 3'd7
`else
    S_C_RMW   = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/csr_trap_ctrl_alu.sv
// Combinational RW/RS/RC new-value computation and write qualification for CSR instructions.
module csr_trap_ctrl_alu
  import csr_trap_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_src,
  input  logic [W-1:0] i_rdata,
  output logic [W-1:0] o_old,
  output logic [W-1:0] o_wdata,
  output logic         o_wen
);

  logic w_sup;

  // Unknown addresses would land in mtvec inside the CSR file, so they must never write.
  assign w_sup = (i_addr == W'(CSR_MSTATUS)) || (i_addr == W'(CSR_MTVEC)) ||
                 (i_addr == W'(CSR_MEPC))    || (i_addr == W'(CSR_MCAUSE));

  assign o_old = w_sup ? i_rdata : '0;

  always_comb begin
    o_wdata = o_old | i_src;
    case (i_op)
      OP_RW:   o_wdata = i_src;
      OP_RC:   o_wdata = o_old & ~i_src;
      default: o_wdata = o_old | i_src;
    endcase
  end

  assign o_wen = w_sup && ((i_op == OP_RW) || ((i_op == OP_RS || i_op == OP_RC) && (i_src != '0)));

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/mret/CSR-instruction sequencer in front of a single-write-port M-mode CSR file.
// Define CSR_TRAP_MSTATUS_EN to add the mstatus update states to trap and mret.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int WIDTH_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  trap_req_i,
  input  logic                  mret_req_i,
  input  logic                  csr_req_i,
  input  logic [1:0]            csr_op_i,
  input  logic [WIDTH_SIZE-1:0] csr_addr_i,
  input  logic [WIDTH_SIZE-1:0] csr_src_i,
  input  logic [WIDTH_SIZE-1:0] pc_i,
  input  logic [WIDTH_SIZE-1:0] cause_i,
  input  logic [WIDTH_SIZE-1:0] csr_rdata_i,
  output logic [WIDTH_SIZE-1:0] csr_raddr_o,
  output logic                  csr_wen_o,
  output logic [WIDTH_SIZE-1:0] csr_waddr_o,
  output logic [WIDTH_SIZE-1:0] csr_wdata_o,
  output logic                  ready_o,
  output logic                  redirect_valid_o,
  output logic [WIDTH_SIZE-1:0] redirect_pc_o,
  output logic                  done_o,
  output logic [WIDTH_SIZE-1:0] csr_old_o
);

  localparam int W = WIDTH_SIZE;

  state_e         r_state, w_next;
  logic [W-1:0]   r_pc, r_cause, r_addr, r_src;
  logic [1:0]     r_op;
  logic [W-1:0]   w_alu_old, w_alu_wdata;
  logic           w_alu_wen;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_addr  <= '0;
      r_src   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (trap_req_i || mret_req_i || csr_req_i)) begin
        r_pc    <= pc_i;
        r_cause <= cause_i;
        r_addr  <= csr_addr_i;
        r_src   <= csr_src_i;
        r_op    <= csr_op_i;
      end
    end
  end

  csr_trap_ctrl_alu #(.W(W)) u_alu (
    .i_op    (r_op),
    .i_addr  (r_addr),
    .i_src   (r_src),
    .i_rdata (csr_rdata_i),
    .o_old   (w_alu_old),
    .o_wdata (w_alu_wdata),
    .o_wen   (w_alu_wen)
  );

  always_comb begin
    w_next           = r_state;
    ready_o          = 1'b0;
    csr_raddr_o      = '0;
    csr_wen_o        = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    done_o           = 1'b0;
    csr_old_o        = '0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (trap_req_i)      w_next = S_T_EPC;
`ifdef CSR_TRAP_MSTATUS_EN
        else if (mret_req_i) w_next = S_M_MST;
`else
        else if (mret_req_i) w_next = S_M_EPC;
`endif
        else if (csr_req_i)  w_next = S_C_RMW;
      end
      S_T_EPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = W'(CSR_MEPC);
        csr_wdata_o = r_pc;
        w_next      = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = W'(CSR_MCAUSE);
        csr_wdata_o = r_cause;
`ifdef CSR_TRAP_MSTATUS_EN
        w_next      = S_T_MST;
`else
        w_next      = S_T_VEC;
`endif
      end
`ifdef CSR_TRAP_MSTATUS_EN
      S_T_MST: begin
        // MPIE <- MIE, MIE <- 0, MPP <- M
        csr_raddr_o        = W'(CSR_MSTATUS);
        csr_wen_o          = 1'b1;
        csr_waddr_o        = W'(CSR_MSTATUS);
        csr_wdata_o        = csr_rdata_i;
        csr_wdata_o[7]     = csr_rdata_i[3];
        csr_wdata_o[3]     = 1'b0;
        csr_wdata_o[12:11] = 2'b11;
        w_next             = S_T_VEC;
      end
      S_M_MST: begin
        csr_raddr_o        = W'(CSR_MSTATUS);
        csr_wen_o          = 1'b1;
        csr_waddr_o        = W'(CSR_MSTATUS);
        csr_wdata_o        = csr_rdata_i;
        csr_wdata_o[3]     = csr_rdata_i[7];
        csr_wdata_o[7]     = 1'b1;
        csr_wdata_o[12:11] = 2'b11;
        w_next             = S_M_EPC;
      end
`endif
      S_T_VEC: begin
        csr_raddr_o      = W'(CSR_MTVEC);
        redirect_valid_o = 1'b1;
        redirect_pc_o    = {csr_rdata_i[W-1:2], 2'b00};
        w_next           = S_IDLE;
      end
      S_M_EPC: begin
        csr_raddr_o      = W'(CSR_MEPC);
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_rdata_i;
        w_next           = S_IDLE;
      end
      S_C_RMW: begin
        csr_raddr_o = r_addr;
        csr_waddr_o = r_addr;
        csr_wen_o   = w_alu_wen;
        csr_wdata_o = w_alu_wdata;
        csr_old_o   = w_alu_old;
        done_o      = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl with a behavioural CSR file (unknown-address writes hit mtvec).
`timescale 1ns/1ps
module tb_csr_trap_ctrl;

`ifdef CSR_TRAP_MSTATUS_EN
  localparam int          LT = 4;
  localparam int          LM = 2;
  localparam logic [31:0] MST_TRAP = 32'h0000_1880;
  localparam logic [31:0] MST_MRET = 32'h0000_1888;
`else
  localparam int          LT = 3;
  localparam int          LM = 1;
  localparam logic [31:0] MST_TRAP = 32'h0000_0008;
  localparam logic [31:0] MST_MRET = 32'h0000_0008;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_req, mret_req, csr_req;
  logic [1:0]  csr_op;
  logic [31:0] csr_addr, csr_src, pc, cause;
  logic [31:0] csr_rdata, csr_raddr, csr_waddr, csr_wdata, redirect_pc, csr_old;
  logic        csr_wen, ready, redirect_valid, done;

  logic        m_init;
  logic [31:0] m_mstatus, m_mepc, m_mcause, m_mtvec;
  int          m_wcnt;
  int          cyc = 0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_done;
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csr_trap_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .trap_req_i(trap_req), .mret_req_i(mret_req), .csr_req_i(csr_req),
    .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_src_i(csr_src),
    .pc_i(pc), .cause_i(cause), .csr_rdata_i(csr_rdata),
    .csr_raddr_o(csr_raddr), .csr_wen_o(csr_wen), .csr_waddr_o(csr_waddr),
    .csr_wdata_o(csr_wdata), .ready_o(ready),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .done_o(done), .csr_old_o(csr_old)
  );

  // CSR file model: combinational read, unknown write addresses fall into mtvec
  always_comb begin
    case (csr_raddr)
      32'h300: csr_rdata = m_mstatus;
      32'h305: csr_rdata = m_mtvec;
      32'h341: csr_rdata = m_mepc;
      32'h342: csr_rdata = m_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk or posedge m_init) begin
    if (m_init) begin
      m_mstatus <= 32'h0000_0008;
      m_mtvec   <= 32'h8000_0103;
      m_mepc    <= 32'h0;
      m_mcause  <= 32'h0;
      m_wcnt    <= 0;
    end else if (csr_wen) begin
      m_wcnt <= m_wcnt + 1;
      case (csr_waddr)
        32'h300: m_mstatus <= csr_wdata;
        32'h341: m_mepc    <= csr_wdata;
        32'h342: m_mcause  <= csr_wdata;
        default: m_mtvec   <= csr_wdata;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic issue(input bit t, input bit m, input bit c, input logic [1:0] op,
                       input logic [31:0] addr, input logic [31:0] src,
                       input logic [31:0] p, input logic [31:0] ca,
                       input bit is_done, input logic [31:0] ev, input int lat);
    exp_t e;
    wait_ready();
    trap_req = t; mret_req = m; csr_req = c;
    csr_op = op; csr_addr = addr; csr_src = src; pc = p; cause = ca;
    e.is_done = is_done; e.val = ev; e.cyc = cyc + lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    trap_req = 1'b0; mret_req = 1'b0; csr_req = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("ready_busy", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    check("ready_after", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; m_init = 1'b1;
    trap_req = 1'b0; mret_req = 1'b0; csr_req = 1'b0;
    csr_op = 2'b00; csr_addr = '0; csr_src = '0; pc = '0; cause = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_wen", {31'd0, csr_wen}, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_raddr", csr_raddr, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    m_init = 1'b0;
    rst_n = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && (redirect_valid || done)) begin
          check("pulse_excl", {31'd0, redirect_valid & done}, 32'd0);
          if (q.size() == 0) begin
            check("unexpected_pulse", {30'd0, redirect_valid, done}, 32'd0);
          end else begin
            e = q.pop_front();
            check("pulse_kind", {31'd0, done}, {31'd0, e.is_done});
            check("pulse_val", done ? csr_old : redirect_pc, e.val);
            check("pulse_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // trap: mtvec low bits masked off in redirect
    issue(1, 0, 0, 2'b00, 0, 0, 32'h8000_0010, 32'd11, 0, 32'h8000_0100, LT);
    check("trap_mepc", m_mepc, 32'h8000_0010);
    check("trap_mcause", m_mcause, 32'd11);
    check("trap_mstatus", m_mstatus, MST_TRAP);

    issue(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 32'h8000_0010, LM);
    check("mret_mstatus", m_mstatus, MST_MRET);

    w0 = m_wcnt;
    issue(0, 0, 1, 2'b10, 32'h300, 32'h0, 0, 0, 1, MST_MRET, 1);
    check("rs0_nowrite", m_wcnt, w0);
    check("rs0_mstatus", m_mstatus, MST_MRET);

    issue(0, 0, 1, 2'b10, 32'h300, 32'h80, 0, 0, 1, MST_MRET, 1);
    check("rs_mstatus", m_mstatus, MST_MRET | 32'h80);

    w0 = m_wcnt;
    issue(0, 0, 1, 2'b01, 32'h7C0, 32'hDEAD, 0, 0, 1, 32'h0, 1);
    check("unsup_nowrite", m_wcnt, w0);
    check("unsup_mtvec", m_mtvec, 32'h8000_0103);

    issue(0, 0, 1, 2'b11, 32'h342, 32'h3, 0, 0, 1, 32'd11, 1);
    check("rc_mcause", m_mcause, 32'd8);

    issue(0, 0, 1, 2'b01, 32'h305, 32'h8000_0200, 0, 0, 1, 32'h8000_0103, 1);
    check("rw_mtvec", m_mtvec, 32'h8000_0200);

    // simultaneous trap + csr: csr is dropped
    issue(1, 0, 1, 2'b01, 32'h342, 32'h55, 32'h8000_0020, 32'd2, 0, 32'h8000_0200, LT);
    check("prio_mepc", m_mepc, 32'h8000_0020);
    check("prio_mcause", m_mcause, 32'd2);

    issue(0, 1, 1, 2'b01, 32'h342, 32'h66, 0, 0, 0, 32'h8000_0020, LM);
    check("prio2_mcause", m_mcause, 32'd2);

    // reset during T_CAUSE
    wait_ready();
    trap_req = 1'b1; pc = 32'h8000_0040; cause = 32'd7;
    @(posedge clk);
    #1 trap_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_wen", {31'd0, csr_wen}, 32'd0);
    check("abort_redirect", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    check("abort_mepc", m_mepc, 32'h8000_0040);
    check("abort_mcause", m_mcause, 32'd2);
    rst_n = 1'b1;

    issue(0, 0, 1, 2'b10, 32'h341, 32'h0, 0, 0, 1, 32'h8000_0040, 1);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
